// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared states, opcode/funct constants and ALU operation codes
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC_R    = 4'd2,
    ST_WB_R      = 4'd3,
    ST_EXEC_I    = 4'd4,
    ST_WB_I      = 4'd5,
    ST_EXEC_ADDR = 4'd6,
    ST_MEM       = 4'd7,
    ST_WB_MEM    = 4'd8,
    ST_EXEC_BR   = 4'd9,
    ST_HALTED    = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SEQ   = 4'd7;
  localparam logic [3:0] ALU_SNE   = 4'd8;
  localparam logic [3:0] ALU_PASSA = 4'd9;
  localparam logic [3:0] ALU_FUNCT = 4'd15;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op >= OP_ADDIU) && (op <= OP_XORI);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - maps state and opcode/funct to ALUControl and immediate extension
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o,
  output logic       ext_sel_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    ext_sel_o     = 1'b0;
    case (state_i)
      ST_EXEC_R:  alu_control_o = (funct_i == FN_JR) ? ALU_PASSA : ALU_FUNCT;
      ST_EXEC_BR: alu_control_o = (opcode_i == OP_BNE) ? ALU_SNE : ALU_SEQ;
      ST_EXEC_I: begin
        // Logical immediates are zero-extended, arithmetic/compare ones sign-extended
        ext_sel_o = (opcode_i == OP_ANDI) || (opcode_i == OP_ORI) || (opcode_i == OP_XORI);
        case (opcode_i)
          OP_SLTI:  alu_control_o = ALU_SLT;
          OP_SLTIU: alu_control_o = ALU_SLTU;
          OP_ANDI:  alu_control_o = ALU_AND;
          OP_ORI:   alu_control_o = ALU_OR;
          OP_XORI:  alu_control_o = ALU_XOR;
          default:  alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// rtl/mips_control_fsm.sv - multi-cycle MIPS control unit with memory handshake and delay-slot branches
module mips_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter bit HALT_ON_PC0 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        stall,
  input  logic        OUTLSB,
  input  logic        PcIs0,
  input  logic        waitrequest,
  output logic        mem_read,
  output logic        mem_write,
  output logic        active,
  output logic        fault,
  output logic        PcEn,
  output logic        IorD,
  output logic        IrWrite,
  output logic        IrSel,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        ExtSel,
  output logic        ALUsel,
  output logic        PCSrc,
  output logic        is_jump,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl
);

  state_t     state_q, state_d;
  logic       bp_q, bp_d;
  logic       fault_q, fault_d;
  logic       active_q, active_d;
  logic [3:0] dec_alu;
  logic       dec_ext;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_instr;

  assign opcode       = Instr[31:26];
  assign funct        = Instr[5:0];
  assign unused_instr = ^Instr[25:6];
  assign active       = active_q;
  assign fault        = fault_q;

  mips_alu_decoder u_alu_dec (
    .state_i       (state_q),
    .opcode_i      (opcode),
    .funct_i       (funct),
    .alu_control_o (dec_alu),
    .ext_sel_o     (dec_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_FETCH;
      bp_q     <= 1'b0;
      fault_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bp_q     <= bp_d;
      fault_q  <= fault_d;
      active_q <= active_d;
    end
  end

  // Every output is gated by active_q so an asynchronous reset drops strobes at once
  always_comb begin
    state_d    = state_q;
    bp_d       = bp_q;
    fault_d    = fault_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    PcEn       = 1'b0;
    IorD       = 1'b0;
    IrWrite    = 1'b0;
    IrSel      = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ExtSel     = 1'b0;
    ALUsel     = 1'b0;
    PCSrc      = 1'b0;
    is_jump    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    if (active_q) begin
      case (state_q)
        ST_FETCH: begin
          if (HALT_ON_PC0 && PcIs0) begin
            state_d = ST_HALTED;
          end else begin
            mem_read   = 1'b1;
            ALUSrcB    = 2'b01;
            ALUControl = dec_alu;
            PCSrc      = bp_q;
            if (!waitrequest) begin
              IrWrite = 1'b1;
              PcEn    = 1'b1;
              bp_d    = 1'b0;
              state_d = ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          IrSel      = 1'b1;
          ALUSrcB    = 2'b11;
          ALUControl = dec_alu;
          if (opcode == OP_RTYPE)                         state_d = ST_EXEC_R;
          else if (opcode == OP_LW || opcode == OP_SW)    state_d = ST_EXEC_ADDR;
          else if (opcode == OP_BEQ || opcode == OP_BNE)  state_d = ST_EXEC_BR;
          else if (is_imm_op(opcode))                     state_d = ST_EXEC_I;
          else begin
            fault_d = 1'b1;
            state_d = ST_HALTED;
          end
        end
        ST_EXEC_R: begin
          ALUSrcA    = 1'b1;
          ALUControl = dec_alu;
          if (funct == FN_JR) begin
            is_jump = 1'b1;
            PcEn    = 1'b1;
            state_d = ST_FETCH;
          end else if (!stall) begin
            state_d = ST_WB_R;
          end
        end
        ST_WB_R: begin
          RegDst   = 1'b1;
          MemToReg = 1'b1;
          ALUsel   = 1'b1;
          RegWrite = 1'b1;
          state_d  = ST_FETCH;
        end
        ST_EXEC_I: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ExtSel     = dec_ext;
          ALUControl = dec_alu;
          state_d    = ST_WB_I;
        end
        ST_WB_I: begin
          MemToReg = 1'b1;
          ALUsel   = 1'b1;
          RegWrite = 1'b1;
          state_d  = ST_FETCH;
        end
        ST_EXEC_ADDR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = dec_alu;
          state_d    = ST_MEM;
        end
        ST_MEM: begin
          IorD      = 1'b1;
          ALUsel    = 1'b1;
          IrSel     = 1'b1;
          mem_read  = (opcode == OP_LW);
          mem_write = (opcode == OP_SW);
          if (!waitrequest) state_d = (opcode == OP_LW) ? ST_WB_MEM : ST_FETCH;
        end
        ST_WB_MEM: begin
          RegWrite = 1'b1;
          state_d  = ST_FETCH;
        end
        ST_EXEC_BR: begin
          // Target was latched in DECODE; it is used after the delay-slot fetch
          ALUSrcA    = 1'b1;
          ALUControl = dec_alu;
          bp_d       = OUTLSB;
          state_d    = ST_FETCH;
        end
        default: state_d = ST_HALTED;
      endcase
    end
    active_d = (state_d != ST_HALTED);
  end

endmodule
